ser_1001_tx: RTL and testbench



---
 rtl/ser_1001_pkg.sv | 15 +
 rtl/ser_1001_tx_pat_match_cnt.sv | 33 +++
 rtl/ser_1001_tx.sv | 122 ++++++++++++
 tb/tb_ser_1001_tx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ser_1001_pkg.sv
// Shared types and constants for the 1001 serial transmitter slice.
// The PRE state is only reachable when SER_1001_PREAMBLE_EN is defined.
package ser_1001_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PRE   = 2'd2
  } state_t;

  localparam int unsigned PAT_LEN = 4;
  localparam logic [PAT_LEN-1:0] PATTERN_1001 = 4'b1001;
  localparam logic [PAT_LEN-1:0] PREAMBLE     = 4'b1001;

endpackage

// File: rtl/ser_1001_tx_pat_match_cnt.sv
// Wire monitor: 3-bit history plus saturating count of PATTERN occurrences,
// overlaps included. Usable standalone as a golden reference.
import ser_1001_pkg::*;

module pat_match_cnt #(
  parameter logic [PAT_LEN-1:0] PATTERN = PATTERN_1001,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  output logic [CNT_W-1:0] cnt
);

  logic [PAT_LEN-2:0] hist;
  logic               match;

  always_comb begin
    match = ({hist, bit_in} == PATTERN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist <= '0;
      cnt  <= '0;
    end else begin
      hist <= {hist[PAT_LEN-3:0], bit_in};
      if (match && (cnt != '1))
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ser_1001_tx.sv
// Parallel-to-serial MSB-first transmitter with on-chip 1001 match counter.
// Define SER_1001_PREAMBLE_EN to prefix every frame with the 1,0,0,1 preamble.
import ser_1001_pkg::*;

module ser_1001_tx #(
  parameter int unsigned        WIDTH   = 8,
  parameter logic [PAT_LEN-1:0] PATTERN = PATTERN_1001,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             data_out,
  output logic             bit_valid,
  output logic             frame_done,
  output logic [CNT_W-1:0] pat_cnt
);

  localparam int unsigned      IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  state_t           state;
  logic [WIDTH-1:0] word;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             accept;
`ifdef SER_1001_PREAMBLE_EN
  logic [1:0]       pidx;
`endif

  always_comb begin
    accept  = load_valid && load_ready;
    idx_nxt = idx - 1'b1;
  end

  // idx names the bit currently on data_out; load_ready is only ever high in
  // IDLE or on the last data bit, so one accept branch serves both cases.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      word       <= '0;
      idx        <= '0;
      data_out   <= 1'b0;
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
      load_ready <= 1'b1;
`ifdef SER_1001_PREAMBLE_EN
      pidx       <= '0;
`endif
    end else if (accept) begin
      word       <= load_data;
      bit_valid  <= 1'b1;
      frame_done <= 1'b0;
      load_ready <= 1'b0;
`ifdef SER_1001_PREAMBLE_EN
      state      <= PRE;
      pidx       <= 2'd3;
      data_out   <= PREAMBLE[3];
`else
      state      <= SHIFT;
      idx        <= LAST_IDX;
      data_out   <= load_data[WIDTH-1];
`endif
    end else begin
      case (state)
        IDLE: begin
          data_out   <= 1'b0;
          bit_valid  <= 1'b0;
          frame_done <= 1'b0;
          load_ready <= 1'b1;
        end
        SHIFT: begin
          if (idx == '0) begin
            state      <= IDLE;
            data_out   <= 1'b0;
            bit_valid  <= 1'b0;
            frame_done <= 1'b0;
            load_ready <= 1'b1;
          end else begin
            idx        <= idx_nxt;
            data_out   <= word[idx_nxt];
            frame_done <= (idx == ONE_IDX);
            load_ready <= (idx == ONE_IDX);
          end
        end
`ifdef SER_1001_PREAMBLE_EN
        PRE: begin
          if (pidx == 2'd0) begin
            state    <= SHIFT;
            idx      <= LAST_IDX;
            data_out <= word[WIDTH-1];
          end else begin
            pidx     <= pidx - 1'b1;
            data_out <= PREAMBLE[pidx - 1'b1];
          end
        end
`endif
        default: begin
          state      <= IDLE;
          data_out   <= 1'b0;
          bit_valid  <= 1'b0;
          frame_done <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

  pat_match_cnt #(
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W)
  ) u_pat_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .bit_in (data_out),
    .cnt    (pat_cnt)
  );

endmodule

// File: tb/tb_ser_1001_tx.sv
// Directed bench for ser_1001_tx; honours SER_1001_PREAMBLE_EN when defined.
module tb_ser_1001_tx;

`ifdef SER_1001_PREAMBLE_EN
  localparam int unsigned FL = 12;
`else
  localparam int unsigned FL = 8;
`endif

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_data;
  logic       data_out;
  logic       bit_valid;
  logic       frame_done;
  logic [7:0] pat_cnt;

  logic [2:0] m_hist;
  logic [7:0] m_cnt;
  int unsigned n_tests;
  int unsigned n_fail;

  ser_1001_tx #(
    .WIDTH (8),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .data_out   (data_out),
    .bit_valid  (bit_valid),
    .frame_done (frame_done),
    .pat_cnt    (pat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic fbit(input logic [7:0] w, input int unsigned k);
    logic [3:0] pre;
    pre = 4'b1001;
`ifdef SER_1001_PREAMBLE_EN
    if (k < 4) return pre[3-k];
    return w[7-(k-4)];
`else
    if (pre == 4'b0000) return 1'b0;
    return w[7-k];
`endif
  endfunction

  // One clock: check outputs after the edge, then fold the expected bit into the model.
  task automatic cycle(input logic eb, input logic ev, input logic ed, input logic er);
    @(posedge clk);
    #1;
    check("data_out",   data_out,   eb);
    check("bit_valid",  bit_valid,  ev);
    check("frame_done", frame_done, ed);
    check("load_ready", load_ready, er);
    check("pat_cnt",    pat_cnt,    m_cnt);
    if (({m_hist, eb} == 4'b1001) && (m_cnt != 8'hFF)) m_cnt++;
    m_hist = {m_hist[1:0], eb};
  endtask

  // Caller has already raised load_valid with w; the first edge here is the accept.
  task automatic send(input logic [7:0] w, input logic more, input logic [7:0] nxt);
    for (int unsigned k = 0; k < FL; k++) begin
      cycle(fbit(w, k), 1'b1, k == FL-1, k == FL-1);
      if (k == FL-1) begin
        load_valid = more;
        load_data  = nxt;
      end else begin
        load_valid = 1'b1;
        load_data  = 8'hA5;
      end
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    load_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_hist = '0;
    m_cnt  = '0;
    check("rst_data_out",   data_out,   1'b0);
    check("rst_bit_valid",  bit_valid,  1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_load_ready", load_ready, 1'b1);
    check("rst_pat_cnt",    pat_cnt,    8'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    m_hist     = '0;
    m_cnt      = '0;

    do_reset();

`ifdef SER_1001_PREAMBLE_EN
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    load_valid = 1'b1;
    load_data  = 8'h00;
    send(8'h00, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("pre_cnt", pat_cnt, 8'd1);
`else
    // Single frame
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    load_valid = 1'b1;
    load_data  = 8'h90;
    send(8'h90, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("single_cnt", pat_cnt, 8'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Overlap and back-to-back from a clean history
    do_reset();
    load_valid = 1'b1;
    load_data  = 8'h92;
    send(8'h92, 1'b1, 8'h99);
    check("b2b_cnt1", pat_cnt, 8'd2);
    send(8'h99, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("b2b_cnt2", pat_cnt, 8'd4);

    // Reset mid-frame
    load_valid = 1'b1;
    load_data  = 8'hFF;
    for (int unsigned k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      load_data = 8'hA5;
    end
    load_valid = 1'b0;
    rst_n      = 1'b0;
    @(posedge clk);
    #1;
    m_hist = '0;
    m_cnt  = '0;
    check("abort_data_out",  data_out,  1'b0);
    check("abort_bit_valid", bit_valid, 1'b0);
    check("abort_pat_cnt",   pat_cnt,   8'd0);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    load_valid = 1'b1;
    load_data  = 8'h09;
    send(8'h09, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("after_abort_cnt", pat_cnt, 8'd1);

    // Saturation: 0x99 contributes two matches per frame
    do_reset();
    load_valid = 1'b1;
    load_data  = 8'h99;
    for (int unsigned f = 0; f < 128; f++)
      send(8'h99, f != 127, 8'h99);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("sat_cnt", pat_cnt, 8'd255);
    load_valid = 1'b1;
    load_data  = 8'h99;
    send(8'h99, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("sat_hold", pat_cnt, 8'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
